// File: rtl/fp16_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp16_pkg                                                         |
// | Shared widths, FSM encoding and result record for fp_normalizer. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package fp16_pkg;

    localparam int MANT_W  = 11;
    localparam int EXP_W   = 5;
    localparam int EXP_MAX = 31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } norm_state_t;

    typedef struct packed {
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  exp;
        logic              zero;
        logic              ovf;
    } norm_result_t;

endpackage
`default_nettype wire

// File: rtl/fp_normalizer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp_normalizer_if                                                 |
// | Input/output valid-ready channels of the post-add normalizer.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface fp_normalizer_if;
    import fp16_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [MANT_W:0]   in_mant;
    logic [EXP_W-1:0]  in_exp;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_zero;
    logic              out_ovf;

    modport master (
        output in_valid, in_mant, in_exp, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_zero, out_ovf
    );

    modport slave (
        input  in_valid, in_mant, in_exp, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_zero, out_ovf
    );

endinterface
`default_nettype wire

// File: rtl/fp_normalizer_left_shift_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | left_shift_stage                                                 |
// | One combinational barrel stage: shift left by 2^k if safe.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module left_shift_stage
    import fp16_pkg::*;
(
    input  logic [MANT_W-1:0] i_mant,
    input  logic [EXP_W-1:0]  i_exp,
    input  logic [1:0]        i_k,
    output logic [MANT_W-1:0] o_mant,
    output logic [EXP_W-1:0]  o_exp,
    output logic              o_did_shift
);

    logic [3:0]        w_amt;
    logic [MANT_W-1:0] w_top;
    logic [EXP_W:0]    w_exp_ext;
    logic [EXP_W:0]    w_amt_ext;
    logic [EXP_W:0]    w_exp_dec;

    always_comb begin
        w_amt     = 4'd1 << i_k;
        // Top 2^k bits of the significand, moved down to the LSBs.
        w_top     = i_mant >> (4'(MANT_W) - w_amt);
        w_exp_ext = {1'b0, i_exp};
        w_amt_ext = (EXP_W+1)'(w_amt);
        w_exp_dec = w_exp_ext - w_amt_ext;

        // Strict compare keeps the exponent at 1 or above.
        o_did_shift = (w_top == '0) && (w_exp_ext > w_amt_ext);
        o_mant      = o_did_shift ? (i_mant << w_amt) : i_mant;
        o_exp       = o_did_shift ? w_exp_dec[EXP_W-1:0] : i_exp;
    end

endmodule
`default_nettype wire

// File: rtl/fp_normalizer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp_normalizer                                                    |
// | Sequential post-add normalizer, one 8/4/2/1 stage per cycle.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fp_normalizer #(
    parameter int MANT_W = fp16_pkg::MANT_W,
    parameter int EXP_W  = fp16_pkg::EXP_W
) (
    input  logic           clk,
    input  logic           rst,
    fp_normalizer_if.slave bus
);
    import fp16_pkg::*;

    localparam logic [1:0] c_IDLE  = ST_IDLE;
    localparam logic [1:0] c_SHIFT = ST_SHIFT;
    localparam logic [1:0] c_HOLD  = ST_HOLD;

    logic [1:0]        r_state;
    logic [1:0]        r_k;
    norm_result_t      r_res;

    logic [EXP_W:0]    w_inc_exp;
    logic [MANT_W-1:0] w_st_mant;
    logic [EXP_W-1:0]  w_st_exp;
    logic              w_did;

    assign w_inc_exp = {1'b0, bus.in_exp} + (EXP_W+1)'(1);

    left_shift_stage u_stage (
        .i_mant      (r_res.mant),
        .i_exp       (r_res.exp),
        .i_k         (r_k),
        .o_mant      (w_st_mant),
        .o_exp       (w_st_exp),
        .o_did_shift (w_did)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_k     <= 2'd3;
            r_res   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_res.zero <= 1'b0;
                        r_res.ovf  <= 1'b0;
                        r_k        <= 2'd3;
                        if (bus.in_mant == '0) begin
                            r_res.mant <= '0;
                            r_res.exp  <= '0;
                            r_res.zero <= 1'b1;
                            r_state    <= c_HOLD;
                        end else if (bus.in_mant[MANT_W]) begin
                            if (w_inc_exp >= (EXP_W+1)'(EXP_MAX)) begin
                                r_res.mant <= '0;
                                r_res.exp  <= EXP_W'(EXP_MAX);
                                r_res.ovf  <= 1'b1;
                            end else begin
                                r_res.mant <= bus.in_mant[MANT_W:1];
                                r_res.exp  <= w_inc_exp[EXP_W-1:0];
                            end
                            r_state <= c_HOLD;
                        end else begin
                            r_res.mant <= bus.in_mant[MANT_W-1:0];
                            r_res.exp  <= bus.in_exp;
                            // Subnormal or already-normalized inputs pass through.
                            r_state    <= (bus.in_exp == '0 || bus.in_mant[MANT_W-1])
                                          ? c_HOLD : c_SHIFT;
                        end
                    end
                end
                c_SHIFT: begin
                    if (w_did) begin
                        r_res.mant <= w_st_mant;
                        r_res.exp  <= w_st_exp;
                    end
                    r_k <= r_k - 2'd1;
                    if (r_k == 2'd0) begin
                        // Hidden bit still clear: encode as subnormal.
                        if (!w_st_mant[MANT_W-1]) begin
                            r_res.exp <= '0;
                        end
                        r_state <= c_HOLD;
                    end
                end
                c_HOLD: begin
                    if (bus.out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == c_IDLE);
    assign bus.out_valid = (r_state == c_HOLD);
    assign bus.out_mant  = r_res.mant;
    assign bus.out_exp   = r_res.exp;
    assign bus.out_zero  = r_res.zero;
    assign bus.out_ovf   = r_res.ovf;

endmodule
`default_nettype wire

// File: tb/tb_fp_normalizer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fp_normalizer                                                 |
// | Scoreboard bench for fp_normalizer.                              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_fp_normalizer;

    typedef struct {
        logic [10:0] mant;
        logic [4:0]  exp;
        logic        zero;
        logic        ovf;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_normalizer_if u_if();

    fp_normalizer u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    // Directed vectors with hand-derived results.
    logic [11:0] dir_m    [8] = '{12'h00F, 12'hC01, 12'h800, 12'h001, 12'h400, 12'h123, 12'h0F0, 12'hFFF};
    logic [4:0]  dir_e    [8] = '{5'd20,   5'd10,   5'd30,   5'd4,    5'd7,    5'd0,    5'd3,    5'd31};
    logic [10:0] dir_xm   [8] = '{11'h780, 11'h600, 11'h000, 11'h008, 11'h400, 11'h123, 11'h3C0, 11'h000};
    logic [4:0]  dir_xe   [8] = '{5'd13,   5'd11,   5'd31,   5'd0,    5'd7,    5'd0,    5'd0,    5'd31};
    logic        dir_xovf [8] = '{1'b0,    1'b0,    1'b1,    1'b0,    1'b0,    1'b0,    1'b0,    1'b1};
    int          dir_lat  [8] = '{4,       0,       0,       4,       0,       0,       4,       0};

    // Reference: leading-zero count, limited so the exponent stays >= 1.
    function automatic exp_t model(input logic [11:0] m, input logic [4:0] e);
        exp_t        r;
        logic [10:0] mm;
        int          lz;
        int          s;
        r.mant = m[10:0]; r.exp = e; r.zero = 1'b0; r.ovf = 1'b0; r.lat = 0;
        if (m == 12'h000) begin
            r.mant = '0; r.exp = '0; r.zero = 1'b1;
        end else if (m[11]) begin
            if (int'(e) + 1 >= 31) begin
                r.mant = '0; r.exp = 5'd31; r.ovf = 1'b1;
            end else begin
                r.mant = m[11:1]; r.exp = e + 5'd1;
            end
        end else if (e != 5'd0 && !m[10]) begin
            mm = m[10:0];
            lz = 0;
            while (!mm[10]) begin
                mm = mm << 1;
                lz++;
            end
            s = (lz < int'(e) - 1) ? lz : int'(e) - 1;
            r.mant = m[10:0] << s;
            r.exp  = r.mant[10] ? (e - 5'(s)) : 5'd0;
            r.lat  = 4;
        end
        return r;
    endfunction

    task automatic send(input logic [11:0] m, input logic [4:0] e, output bit ok);
        u_if.in_valid = 1'b1;
        u_if.in_mant  = m;
        u_if.in_exp   = e;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (u_if.in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        u_if.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output bit ok);
        lat = 0;
        while (!u_if.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = u_if.out_valid;
    endtask

    task automatic take();
        u_if.out_ready = 1'b1;
        @(posedge clk); #1;
        u_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (u_if.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", u_if.in_ready);
        end
        n_cmp++;
        if (u_if.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", u_if.out_valid);
        end
        n_cmp++;
        if ({u_if.out_mant, u_if.out_exp, u_if.out_zero, u_if.out_ovf} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got mant=%h exp=%0d zero=%b ovf=%b want all 0",
                     u_if.out_mant, u_if.out_exp, u_if.out_zero, u_if.out_ovf);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        bit   ok;
        int   lat;
        exp_t x;
        for (int i = 0; i < 8; i++) begin
            x.mant = dir_xm[i]; x.exp = dir_xe[i]; x.zero = 1'b0; x.ovf = dir_xovf[i]; x.lat = dir_lat[i];
            sb.push_back(x);
            send(dir_m[i], dir_e[i], ok);
            wait_out(lat, ok);
            x = sb.pop_front();
            n_cmp++;
            if (!ok) begin
                n_fail++; $display("FAIL dir%0d_timeout: out_valid=0 want 1", i);
            end
            n_cmp++;
            if ({u_if.out_mant, u_if.out_exp, u_if.out_zero, u_if.out_ovf} !== {x.mant, x.exp, x.zero, x.ovf}) begin
                n_fail++;
                $display("FAIL dir%0d_result: got mant=%h exp=%0d zero=%b ovf=%b want mant=%h exp=%0d zero=%b ovf=%b",
                         i, u_if.out_mant, u_if.out_exp, u_if.out_zero, u_if.out_ovf, x.mant, x.exp, x.zero, x.ovf);
            end
            n_cmp++;
            if (lat != x.lat) begin
                n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, x.lat);
            end
            take();
        end
    endtask

    task automatic test_backpressure();
        bit   ok;
        int   lat;
        exp_t x;
        logic [17:0] held;
        x.mant = '0; x.exp = '0; x.zero = 1'b1; x.ovf = 1'b0; x.lat = 0;
        sb.push_back(x);
        send(12'h000, 5'd9, ok);
        wait_out(lat, ok);
        x = sb.pop_front();
        held = {u_if.out_mant, u_if.out_exp, u_if.out_zero, u_if.out_ovf};
        n_cmp++;
        if (!ok || held !== {x.mant, x.exp, x.zero, x.ovf}) begin
            n_fail++; $display("FAIL bp_zero_result: got valid=%b res=%h want valid=1 res=%h",
                               ok, held, {x.mant, x.exp, x.zero, x.ovf});
        end
        // Second request waits while the output is stalled.
        u_if.in_valid = 1'b1; u_if.in_mant = 12'h00F; u_if.in_exp = 5'd20;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({u_if.out_valid, u_if.in_ready} !== 2'b10) begin
                n_fail++; $display("FAIL bp_hold%0d_hs: got valid=%b ready=%b want valid=1 ready=0",
                                   c, u_if.out_valid, u_if.in_ready);
            end
            n_cmp++;
            if ({u_if.out_mant, u_if.out_exp, u_if.out_zero, u_if.out_ovf} !== held) begin
                n_fail++; $display("FAIL bp_hold%0d_stable: got %h want %h",
                                   c, {u_if.out_mant, u_if.out_exp, u_if.out_zero, u_if.out_ovf}, held);
            end
        end
        take();
        n_cmp++;
        if ({u_if.out_valid, u_if.in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL bp_after_xfer: got valid=%b ready=%b want valid=0 ready=1",
                               u_if.out_valid, u_if.in_ready);
        end
        x = model(12'h00F, 5'd20);
        sb.push_back(x);
        @(posedge clk); #1;
        u_if.in_valid = 1'b0;
        wait_out(lat, ok);
        x = sb.pop_front();
        n_cmp++;
        if (!ok || {u_if.out_mant, u_if.out_exp, u_if.out_zero, u_if.out_ovf} !== {x.mant, x.exp, x.zero, x.ovf}
            || lat != x.lat) begin
            n_fail++; $display("FAIL bp_second: got valid=%b mant=%h exp=%0d lat=%0d want mant=%h exp=%0d lat=%0d",
                               ok, u_if.out_mant, u_if.out_exp, lat, x.mant, x.exp, x.lat);
        end
        take();
    endtask

    task automatic test_reset_midshift();
        bit   ok;
        bit   seen;
        int   lat;
        exp_t x;
        send(12'h00F, 5'd20, ok);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({u_if.in_ready, u_if.out_valid} !== 2'b10) begin
            n_fail++; $display("FAIL rst_mid_hs: got ready=%b valid=%b want ready=1 valid=0",
                               u_if.in_ready, u_if.out_valid);
        end
        n_cmp++;
        if ({u_if.out_mant, u_if.out_exp, u_if.out_zero, u_if.out_ovf} !== 18'h0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got %h want 0",
                               {u_if.out_mant, u_if.out_exp, u_if.out_zero, u_if.out_ovf});
        end
        #2 rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (u_if.out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_fail++; $display("FAIL rst_mid_discard: got out_valid=1 want 0");
        end
        x = model(12'hC01, 5'd10);
        sb.push_back(x);
        send(12'hC01, 5'd10, ok);
        wait_out(lat, ok);
        x = sb.pop_front();
        n_cmp++;
        if (!ok || {u_if.out_mant, u_if.out_exp, u_if.out_zero, u_if.out_ovf} !== {x.mant, x.exp, x.zero, x.ovf}
            || lat != x.lat) begin
            n_fail++; $display("FAIL rst_mid_next: got valid=%b mant=%h exp=%0d lat=%0d want mant=%h exp=%0d lat=%0d",
                               ok, u_if.out_mant, u_if.out_exp, lat, x.mant, x.exp, x.lat);
        end
        take();
    endtask

    task automatic test_back_to_back();
        bit          ok;
        int          lat;
        int          t;
        int          acc;
        int          prev_acc;
        int          prev_lat;
        logic [11:0] m;
        logic [4:0]  e;
        exp_t        x;
        u_if.out_ready = 1'b1;
        m = 12'($urandom_range(0, 4095) >> $urandom_range(0, 11));
        e = 5'($urandom_range(0, 31));
        u_if.in_valid = 1'b1; u_if.in_mant = m; u_if.in_exp = e;
        prev_acc = -1;
        prev_lat = 0;
        for (int i = 0; i < 24; i++) begin
            t = 0;
            while (!u_if.in_ready && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            @(posedge clk); #1;
            acc = cyc;
            sb.push_back(model(m, e));
            if (prev_acc >= 0) begin
                n_cmp++;
                if (acc - prev_acc != ((prev_lat == 4) ? 6 : 2)) begin
                    n_fail++; $display("FAIL b2b%0d_interval: got %0d want %0d",
                                       i, acc - prev_acc, (prev_lat == 4) ? 6 : 2);
                end
            end
            m = 12'($urandom_range(0, 4095) >> $urandom_range(0, 11));
            e = 5'($urandom_range(0, 31));
            u_if.in_mant = m; u_if.in_exp = e;
            wait_out(lat, ok);
            x = sb.pop_front();
            n_cmp++;
            if (!ok || {u_if.out_mant, u_if.out_exp, u_if.out_zero, u_if.out_ovf} !== {x.mant, x.exp, x.zero, x.ovf}
                || lat != x.lat) begin
                n_fail++;
                $display("FAIL b2b%0d_result: got valid=%b mant=%h exp=%0d zero=%b ovf=%b lat=%0d want mant=%h exp=%0d zero=%b ovf=%b lat=%0d",
                         i, ok, u_if.out_mant, u_if.out_exp, u_if.out_zero, u_if.out_ovf, lat,
                         x.mant, x.exp, x.zero, x.ovf, x.lat);
            end
            prev_acc = acc;
            prev_lat = x.lat;
        end
        u_if.in_valid = 1'b0;
        @(posedge clk); #1;
        u_if.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        u_if.in_valid  = 1'b0;
        u_if.in_mant   = '0;
        u_if.in_exp    = '0;
        u_if.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midshift();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
